// File: rtl/fp16_op_sched.sv
// Round-robin scheduler sharing one combinational fp16 add/sub/mul unit between N_REQ requesters.
// Optional macro FP16_SCHED_PRIO0_EN gives requester 0 strict priority over the round-robin.
module fp16_op_sched #(
    parameter int N_REQ  = 4,
    parameter int FU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [2*N_REQ-1:0]         i_req_op,
    input  logic [16*N_REQ-1:0]        i_req_a,
    input  logic [16*N_REQ-1:0]        i_req_b,
    output logic [1:0]                 o_fu_op,
    output logic [15:0]                o_fu_a,
    output logic [15:0]                o_fu_b,
    input  logic [15:0]                i_fu_res,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   o_rsp_id,
    output logic [15:0]                o_rsp_res
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic [IDW-1:0] ptr_next;
    int             scan_idx;

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (i_req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(scan_idx);
            end
        end
`ifdef FP16_SCHED_PRIO0_EN
        if (i_req_valid[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end
`endif
    end

    always_comb begin
        ptr_next = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    if (cnt == '0) state_next = RESP;
            RESP:    if (i_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is purely combinational; gating with rst_n keeps every output low during reset.
    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && grant_any && rst_n) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            o_fu_op     <= 2'b00;
            o_fu_a      <= 16'h0000;
            o_fu_b      <= 16'h0000;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_res   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        o_fu_op <= i_req_op[int'(grant_idx) * 2 +: 2];
                        o_fu_a  <= i_req_a[int'(grant_idx) * 16 +: 16];
                        o_fu_b  <= i_req_b[int'(grant_idx) * 16 +: 16];
                        gnt     <= grant_idx;
                        cnt     <= CW'(FU_LAT - 1);
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        o_rsp_res   <= (o_fu_op == 2'b11) ? 16'h7E00 : i_fu_res;
                        o_rsp_id    <= gnt;
                        o_rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
`ifdef FP16_SCHED_PRIO0_EN
                        if (gnt != '0) begin
                            ptr <= ptr_next;
                        end
`else
                        ptr <= ptr_next;
`endif
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_op_sched.sv
// Self-checking bench for fp16_op_sched: table-driven single ops plus reset, round-robin,
// priority and backpressure sequences, with a scoreboard fed on each accepted request.
module tb_fp16_op_sched;

    localparam int N_REQ  = 4;
    localparam int FU_LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [2*N_REQ-1:0]   req_op;
    logic [16*N_REQ-1:0]  req_a;
    logic [16*N_REQ-1:0]  req_b;
    logic [1:0]           fu_op;
    logic [15:0]          fu_a;
    logic [15:0]          fu_b;
    logic [15:0]          fu_res;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [15:0]          rsp_res;

    typedef struct {
        int          k;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] res;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    vec_t        vecs[8];
    logic [15:0] exp_res_for[N_REQ];
    int          acc_cnt[N_REQ];
    int          ready_cycles[N_REQ];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          last_accept_cycle = 0;
    int          rsp_rise_cycle = 0;
    logic        rsp_valid_q = 1'b0;

    always #5 clk = ~clk;

    fp16_op_sched #(.N_REQ(N_REQ), .FU_LAT(FU_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_fu_op     (fu_op),
        .o_fu_a      (fu_a),
        .o_fu_b      (fu_b),
        .i_fu_res    (fu_res),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_res   (rsp_res)
    );

    // Behavioural stand-in for the shared fp16 unit, done in real arithmetic.
    function automatic real pow2(int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp16_to_real(logic [15:0] h);
        real v;
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        if (e == 0) v = $itor(m) * pow2(-24);
        else        v = $itor(m + 1024) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_fp16(real r);
        logic s;
        real  m;
        int   e;
        int   frac;
        if (r != r) return 16'h7E00;
        s = (r < 0.0);
        m = s ? -r : r;
        if (m == 0.0) return {s, 15'h0000};
        if (m >= 65520.0) return {s, 15'h7C00};
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        if (e < -14) begin
            frac = $rtoi((s ? -r : r) * 16777216.0 + 0.5);
            return {s, 15'(frac)};
        end
        frac = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (frac == 1024) begin frac = 0; e++; end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(frac)};
    endfunction

    function automatic logic [15:0] fu_model(logic [1:0] op, logic [15:0] a, logic [15:0] b);
        real x;
        real y;
        real z;
        if (op == 2'b11) return 16'h1111;
        if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
            if (a[14:0] > 15'h7C00 || b[14:0] > 15'h7C00) return 16'h7E00;
            if (a[14:10] == 5'h1F) return a;
            return (op == 2'b01) ? {~b[15], b[14:0]} : b;
        end
        x = fp16_to_real(a);
        y = fp16_to_real(b);
        case (op)
            2'b00:   z = x + y;
            2'b01:   z = x - y;
            default: z = x * y;
        endcase
        return real_to_fp16(z);
    endfunction

    assign fu_res = fu_model(fu_op, fu_a, fu_b);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("rsp_unexpected", 1, 0);
        end else begin
            e = sb.pop_front();
            check("rsp_id", int'(rsp_id), e.id);
            check("rsp_res", int'(rsp_res), int'(e.res));
        end
    endtask

    // Monitor on the falling edge: grant one-hot check, scoreboard push on accept, pop on response.
    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            check("ready_onehot", int'($countones(req_ready) <= 1), 1);
            for (int k = 0; k < N_REQ; k++) begin
                if (req_ready[k]) ready_cycles[k]++;
                if (req_ready[k] && req_valid[k]) begin
                    acc_cnt[k]++;
                    grant_log.push_back(k);
                    sb.push_back('{k, exp_res_for[k]});
                    last_accept_cycle = cycle;
                end
            end
            if (rsp_valid && !rsp_valid_q) rsp_rise_cycle = cycle;
            if (rsp_valid && rsp_ready) checkOutput();
        end
        rsp_valid_q = rsp_valid;
    end

    task automatic setRequest(input vec_t v);
        req_op[2*v.k +: 2]  = v.op;
        req_a[16*v.k +: 16] = v.a;
        req_b[16*v.k +: 16] = v.b;
        exp_res_for[v.k]    = v.res;
    endtask

    task automatic applyStimulus(input vec_t v);
        int start;
        start = acc_cnt[v.k];
        setRequest(v);
        req_valid[v.k] = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #2;
            if (acc_cnt[v.k] != start) break;
        end
        check("accept_timeout", int'(acc_cnt[v.k] != start), 1);
        req_valid[v.k] = 1'b0;
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 100; t++) begin
            if (sb.size() == 0 && !rsp_valid) break;
            @(posedge clk); #2;
        end
        check("drain_timeout", int'(sb.size() == 0 && !rsp_valid), 1);
    endtask

    task automatic collectGrants(input int n);
        int base;
        base = grant_log.size();
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #2;
            if (grant_log.size() >= base + n) break;
        end
        req_valid = '0;
        check("grant_timeout", int'(grant_log.size() >= base + n), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   base;
        int   rr_exp[5];
        int   pr_exp[2];
        logic [1:0]  held_id;
        logic [15:0] held_res;

        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            exp_res_for[k] = 16'h0; acc_cnt[k] = 0; ready_cycles[k] = 0;
        end

        vecs[0] = '{1, 2'b00, 16'h3C00, 16'h4000, 16'h4200};
        vecs[1] = '{0, 2'b10, 16'h4000, 16'h4200, 16'h4600};
        vecs[2] = '{2, 2'b01, 16'h3C00, 16'h3C00, 16'h0000};
        vecs[3] = '{3, 2'b11, 16'h1234, 16'h5678, 16'h7E00};
        vecs[4] = '{0, 2'b10, 16'h3C00, 16'h3C00, 16'h3C00};
        vecs[5] = '{2, 2'b01, 16'h4200, 16'h3C00, 16'h4000};
        vecs[6] = '{3, 2'b00, 16'h4000, 16'h4000, 16'h4400};
        vecs[7] = '{1, 2'b00, 16'h7C00, 16'h3C00, 16'h7C00};

        repeat (3) @(posedge clk);
        #2;
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_fu_a", int'(fu_a), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        $display("[TB] single request with latency check");
        applyStimulus(vecs[0]);
        waitDrain();
        check("single_latency", rsp_rise_cycle - last_accept_cycle, FU_LAT + 1);
        check("single_ready_cycles", ready_cycles[1], 1);

        $display("[TB] operation table");
        for (int i = 1; i < 8; i++) begin
            applyStimulus(vecs[i]);
            waitDrain();
        end

        $display("[TB] reset mid-EXEC");
        applyStimulus('{2, 2'b00, 16'h3C00, 16'h4000, 16'h4200});
        req_valid[3] = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_fu_op", int'(fu_op), 0);
        check("rst_fu_a", int'(fu_a), 0);
        check("rst_fu_b", int'(fu_b), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_res", int'(rsp_res), 0);
        check("rst_req_ready", int'(req_ready), 0);
        sb.delete();
        @(posedge clk); #2;

        $display("[TB] round-robin with all requesters valid");
        setRequest('{0, 2'b00, 16'h3C00, 16'h3C00, 16'h4000});
        setRequest('{1, 2'b10, 16'h4000, 16'h4000, 16'h4400});
        setRequest('{2, 2'b01, 16'h4200, 16'h3C00, 16'h4000});
        setRequest('{3, 2'b00, 16'h3C00, 16'h4000, 16'h4200});
        base = grant_log.size();
        rst_n = 1'b1;
        req_valid = '1;
        collectGrants(5);
`ifdef FP16_SCHED_PRIO0_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            if (grant_log.size() > base + i) check("rr_grant", grant_log[base + i], rr_exp[i]);
        end
        waitDrain();

        $display("[TB] requester 0 against pointer 2");
        applyStimulus('{1, 2'b00, 16'h3C00, 16'h3C00, 16'h4000});
        waitDrain();
        setRequest('{0, 2'b10, 16'h4000, 16'h4000, 16'h4400});
        setRequest('{2, 2'b00, 16'h4000, 16'h4200, 16'h4500});
        base = grant_log.size();
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        collectGrants(2);
`ifdef FP16_SCHED_PRIO0_EN
        pr_exp = '{0, 0};
`else
        pr_exp = '{2, 0};
`endif
        for (int i = 0; i < 2; i++) begin
            if (grant_log.size() > base + i) check("prio_grant", grant_log[base + i], pr_exp[i]);
        end
        waitDrain();

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus('{3, 2'b00, 16'h3C00, 16'h4000, 16'h4200});
        setRequest('{1, 2'b00, 16'h4000, 16'h4000, 16'h4400});
        req_valid[1] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("bp_rsp_valid_rise", int'(rsp_valid), 1);
        held_id  = rsp_id;
        held_res = rsp_res;
        check("bp_rsp_id", int'(held_id), 3);
        check("bp_rsp_res", int'(held_res), 16'h4200);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_valid_stable", int'(rsp_valid), 1);
            check("bp_id_stable", int'(rsp_id), int'(held_id));
            check("bp_res_stable", int'(rsp_res), int'(held_res));
            check("bp_no_ready", int'(req_ready), 0);
        end
        @(posedge clk); #2;
        base = acc_cnt[1];
        rsp_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #2;
            if (acc_cnt[1] != base) break;
        end
        check("bp_next_grant", int'(acc_cnt[1] != base), 1);
        req_valid[1] = 1'b0;
        waitDrain();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
